// File: rtl/rgb_sequencer_if.sv
// rtl/rgb_sequencer_if.sv - table-write, playback-control and LED-status bundle for rgb_sequencer
interface rgb_sequencer_if #(
    parameter int STEPS     = 8,
    parameter int DUR_WIDTH = 8
);
    localparam int AW = $clog2(STEPS);

    logic                 i_wr;
    logic [AW-1:0]        i_waddr;
    logic [DUR_WIDTH+2:0] i_wdata;
    logic                 i_start;
    logic                 i_stop;
    logic                 i_loop;
    logic [2:0]           o_rgb;
    logic [AW-1:0]        o_step;
    logic                 o_busy;
    logic                 o_done;

    modport master (
        output i_wr, i_waddr, i_wdata, i_start, i_stop, i_loop,
        input  o_rgb, o_step, o_busy, o_done
    );

    modport slave (
        input  i_wr, i_waddr, i_wdata, i_start, i_stop, i_loop,
        output o_rgb, o_step, o_busy, o_done
    );
endinterface

// File: rtl/rgb_sequencer.sv
// rtl/rgb_sequencer.sv - table-driven RGB step player with prescaled durations, loop and stop
module rgb_sequencer #(
    parameter int PRESCALE  = 20,
    parameter int STEPS     = 8,
    parameter int DUR_WIDTH = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    rgb_sequencer_if.slave seq
);
    localparam int AW = $clog2(STEPS);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state, state_n;
    logic [DUR_WIDTH+2:0] table_q [STEPS];
    logic [PRESCALE-1:0]  presc, presc_n;
    logic [DUR_WIDTH-1:0] remaining, remaining_n;
    logic [AW-1:0]        step, step_n;
    logic [2:0]           rgb, rgb_n;
    logic                 busy, busy_n;
    logic                 done, done_n;

    logic [AW:0]          next_idx;
    logic [AW-1:0]        chosen;
    logic                 end_pat;

    function automatic logic [DUR_WIDTH-1:0] dur_of(input logic [DUR_WIDTH+2:0] e);
        return e[DUR_WIDTH+2:3];
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n     = state;
        presc_n     = presc;
        remaining_n = remaining;
        step_n      = step;
        rgb_n       = rgb;
        busy_n      = busy;
        done_n      = 1'b0;
        next_idx    = {1'b0, step} + 1'b1;
        chosen      = '0;
        end_pat     = 1'b0;
        case (state)
            IDLE: begin
                presc_n     = '0;
                remaining_n = '0;
                step_n      = '0;
                rgb_n       = 3'b000;
                busy_n      = 1'b0;
                if (seq.i_start && !seq.i_stop) begin
                    if (dur_of(table_q[0]) != '0) begin
                        state_n     = RUN;
                        remaining_n = dur_of(table_q[0]);
                        rgb_n       = table_q[0][2:0];
                        busy_n      = 1'b1;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            RUN: begin
                if (seq.i_stop) begin
                    state_n     = IDLE;
                    presc_n     = '0;
                    remaining_n = '0;
                    step_n      = '0;
                    rgb_n       = 3'b000;
                    busy_n      = 1'b0;
                end else begin
                    presc_n = presc + 1'b1;
                    if (&presc) begin
                        if (remaining == DUR_WIDTH'(1)) begin
                            // Past the last entry or at a zero-duration marker: wrap or finish.
                            if (next_idx == (AW+1)'(STEPS) ||
                                dur_of(table_q[next_idx[AW-1:0]]) == '0) begin
                                if (seq.i_loop) chosen = '0;
                                else            end_pat = 1'b1;
                            end else begin
                                chosen = next_idx[AW-1:0];
                            end
                            if (!end_pat && dur_of(table_q[chosen]) == '0)
                                end_pat = 1'b1;
                            if (end_pat) begin
                                state_n     = IDLE;
                                presc_n     = '0;
                                remaining_n = '0;
                                step_n      = '0;
                                rgb_n       = 3'b000;
                                busy_n      = 1'b0;
                                done_n      = 1'b1;
                            end else begin
                                step_n      = chosen;
                                remaining_n = dur_of(table_q[chosen]);
                                rgb_n       = table_q[chosen][2:0];
                            end
                        end else begin
                            remaining_n = remaining - 1'b1;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            presc     <= '0;
            remaining <= '0;
            step      <= '0;
            rgb       <= 3'b000;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < STEPS; i++) table_q[i] <= '0;
        end else begin
            presc     <= presc_n;
            remaining <= remaining_n;
            step      <= step_n;
            rgb       <= rgb_n;
            busy      <= busy_n;
            done      <= done_n;
            // Loads above read the pre-write contents, so a same-cycle write is seen next time.
            if (seq.i_wr) table_q[seq.i_waddr] <= seq.i_wdata;
        end
    end

    assign seq.o_rgb  = rgb;
    assign seq.o_step = step;
    assign seq.o_busy = busy;
    assign seq.o_done = done;
endmodule

// File: tb/tb_rgb_sequencer.sv
// tb/tb_rgb_sequencer.sv - directed self-checking bench for rgb_sequencer
module tb_rgb_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    rgb_sequencer_if #(.STEPS(4), .DUR_WIDTH(8)) bus ();

    rgb_sequencer #(.PRESCALE(2), .STEPS(4), .DUR_WIDTH(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .seq   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d, input int c);
        bus.i_wr    = 1'b1;
        bus.i_waddr = a[1:0];
        bus.i_wdata = {d[7:0], c[2:0]};
        step_clk();
        bus.i_wr    = 1'b0;
    endtask

    task automatic start_pulse();
        bus.i_start = 1'b1;
        step_clk();
        bus.i_start = 1'b0;
    endtask

    task automatic expect_run(input string tag, input int c, input int s, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_rgb"},  bus.o_rgb,  c);
            check({tag, "_step"}, bus.o_step, s);
            check({tag, "_busy"}, bus.o_busy, 1);
            check({tag, "_done"}, bus.o_done, 0);
            step_clk();
        end
    endtask

    task automatic expect_idle(input string tag, input int dn);
        check({tag, "_rgb"},  bus.o_rgb,  0);
        check({tag, "_step"}, bus.o_step, 0);
        check({tag, "_busy"}, bus.o_busy, 0);
        check({tag, "_done"}, bus.o_done, dn);
    endtask

    task automatic expect_done(input string tag);
        expect_idle(tag, 1);
        step_clk();
        expect_idle({tag, "_after"}, 0);
    endtask

    initial begin
        bus.i_wr = 1'b0; bus.i_waddr = '0; bus.i_wdata = '0;
        bus.i_start = 1'b0; bus.i_stop = 1'b0; bus.i_loop = 1'b0;
        step_clk();
        rst = 1'b0;
        expect_idle("reset", 0);

        // basic play: 001 x8, 010 x4, then done
        wr(0, 2, 1); wr(1, 1, 2); wr(2, 0, 0);
        start_pulse();
        expect_run("basic_e0", 1, 0, 8);
        expect_run("basic_e1", 2, 1, 4);
        expect_done("basic_end");

        // loop, then drop loop on the second pass
        bus.i_loop = 1'b1;
        start_pulse();
        expect_run("loop_p1e0", 1, 0, 8);
        expect_run("loop_p1e1", 2, 1, 4);
        expect_run("loop_p2e0", 1, 0, 8);
        bus.i_loop = 1'b0;
        expect_run("loop_p2e1", 2, 1, 4);
        expect_done("loop_end");

        // full table, then with loop wrapping step 3 to step 0
        wr(0, 1, 1); wr(1, 1, 2); wr(2, 1, 3); wr(3, 1, 4);
        start_pulse();
        for (int s = 0; s < 4; s++) expect_run("full", s + 1, s, 4);
        expect_done("full_end");
        bus.i_loop = 1'b1;
        start_pulse();
        for (int s = 0; s < 4; s++) expect_run("fullloop_p1", s + 1, s, 4);
        bus.i_loop = 1'b0;
        for (int s = 0; s < 4; s++) expect_run("fullloop_p2", s + 1, s, 4);
        expect_done("fullloop_end");

        // stop in cycle 5 of step 0
        wr(0, 2, 1);
        start_pulse();
        expect_run("stop_pre", 1, 0, 4);
        bus.i_stop = 1'b1;
        expect_run("stop_c5", 1, 0, 1);
        bus.i_stop = 1'b0;
        for (int i = 0; i < 6; i++) begin
            expect_idle("stop_idle", 0);
            step_clk();
        end

        // stop coincident with a step end
        start_pulse();
        expect_run("stopend_pre", 1, 0, 7);
        bus.i_stop = 1'b1;
        expect_run("stopend_c8", 1, 0, 1);
        bus.i_stop = 1'b0;
        expect_idle("stopend_idle", 0);
        step_clk();
        expect_idle("stopend_idle2", 0);

        // write collision on the entry being loaded
        wr(0, 1, 1); wr(1, 1, 2); wr(2, 1, 3); wr(3, 0, 0);
        start_pulse();
        expect_run("coll_e0", 1, 0, 3);
        bus.i_wr = 1'b1; bus.i_waddr = 2'd1; bus.i_wdata = {8'd1, 3'd6};
        expect_run("coll_e0_last", 1, 0, 1);
        bus.i_wr = 1'b0;
        expect_run("coll_e1_old", 2, 1, 4);
        expect_run("coll_e2", 3, 2, 4);
        expect_done("coll_end");
        start_pulse();
        expect_run("coll2_e0", 1, 0, 4);
        expect_run("coll2_e1_new", 6, 1, 4);
        expect_run("coll2_e2", 3, 2, 4);
        expect_done("coll2_end");

        // reset mid-run clears outputs and table
        start_pulse();
        expect_run("rst_pre", 1, 0, 2);
        rst = 1'b1;
        step_clk();
        rst = 1'b0;
        expect_idle("rst_idle", 0);
        start_pulse();
        expect_done("rst_empty");

        // empty pattern explicitly written
        wr(0, 0, 7);
        start_pulse();
        expect_done("empty");

        // start held through done restarts on the next cycle
        wr(0, 1, 5);
        bus.i_start = 1'b1;
        step_clk();
        expect_run("b2b_p1", 5, 0, 4);
        expect_idle("b2b_done", 1);
        step_clk();
        bus.i_start = 1'b0;
        expect_run("b2b_p2", 5, 0, 4);
        expect_done("b2b_end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
